// File: rtl/riscv_board_top.sv
// Board wrapper: clock-enable stepping of the core, debug-word select, 7-segment scanner and LEDs.
// Define SIM_FAST_DIV_EN to force the slow-step and scan dividers to 2^4 for short simulations.

module pipeline_cpu (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic [31:0] alu_out,
  input  logic [4:0]  dbg_rf_addr,
  output logic [31:0] dbg_rf_data,
  input  logic [5:0]  dbg_dm_addr,
  output logic [31:0] dbg_dm_data
);
  // Compact RV32I subset core; retires exactly one instruction per ce.
  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];
  logic [31:0] dm_q [64];
  logic [31:0] instr, rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_j, alu, wb_v;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        wr_rf, wr_dm;

  always_comb begin
    instr = 32'h0000_0013;
    case (pc_q[7:2])
      6'd0:  instr = 32'h0010_0093;  // addi x1, x0, 1
      6'd1:  instr = 32'h0020_0113;  // addi x2, x0, 2
      6'd2:  instr = 32'h0020_81B3;  // add  x3, x1, x2
      6'd3:  instr = 32'h0030_2023;  // sw   x3, 0(x0)
      6'd4:  instr = 32'h0000_2203;  // lw   x4, 0(x0)
      6'd18: instr = 32'h1230_0293;  // addi x5, x0, 0x123
      6'd63: instr = 32'hF05F_F06F;  // jal  x0, -252
      default: instr = 32'h0000_0013;
    endcase
  end

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1_v  = rf_q[instr[19:15]];
  assign rs2_v  = rf_q[instr[24:20]];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    alu   = rs1_v + imm_i;
    wr_rf = 1'b0;
    wr_dm = 1'b0;
    pc_d  = pc_q + 32'd4;
    case (opcode)
      7'b0010011: wr_rf = 1'b1;
      7'b0110011: begin
        alu   = rs1_v + rs2_v;
        wr_rf = 1'b1;
      end
      7'b0000011: wr_rf = 1'b1;
      7'b0100011: begin
        alu   = rs1_v + imm_s;
        wr_dm = 1'b1;
      end
      7'b1100011: begin
        alu = rs1_v - rs2_v;
        if (alu == 32'd0) pc_d = pc_q + imm_b;
      end
      7'b1101111: begin
        alu   = pc_q + 32'd4;
        wr_rf = 1'b1;
        pc_d  = pc_q + imm_j;
      end
      default: ;
    endcase
  end

  assign wb_v = (opcode == 7'b0000011) ? dm_q[alu[7:2]] : alu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      for (int i = 0; i < 64; i++) dm_q[i] <= '0;
    end else if (ce) begin
      pc_q <= pc_d;
      if (wr_rf && rd != 5'd0) rf_q[rd] <= wb_v;
      if (wr_dm) dm_q[alu[7:2]] <= rs2_v;
    end
  end

  assign pc_out      = pc_q;
  assign instr_out   = instr;
  assign alu_out     = alu;
  assign dbg_rf_data = rf_q[dbg_rf_addr];
  assign dbg_dm_data = dm_q[dbg_dm_addr];
endmodule

module riscv_board_top #(
  parameter int FAST_DIV_LOG2 = 1,
  parameter int SLOW_DIV_LOG2 = 24,
  parameter int SCAN_DIV_LOG2 = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] sw_i,
  output logic [15:0] led_o,
  output logic [7:0]  disp_seg_o,
  output logic [7:0]  disp_an_o
);
`ifdef SIM_FAST_DIV_EN
  localparam int SLOW_L = 4;
  localparam int SCAN_L = 4;
`else
  localparam int SLOW_L = SLOW_DIV_LOG2;
  localparam int SCAN_L = SCAN_DIV_LOG2;
`endif
  localparam logic [31:0] FAST_MASK = (32'd1 << FAST_DIV_LOG2) - 32'd1;
  localparam logic [31:0] SLOW_MASK = (32'd1 << SLOW_L) - 32'd1;

  logic [31:0] clkdiv_q;
  logic        ce_q, ce_d;
  logic [4:0]  dbg_idx_q;
  logic [31:0] disp_data_q, disp_data_d;
  logic [15:0] led_q, led_d;
  logic [7:0]  seg_q, seg_d, an_q, an_d;
  logic [31:0] div_mask;
  logic        slow_tick;
  logic [2:0]  scan_idx;
  logic [3:0]  nibble;
  logic [31:0] pc_out, instr_out, alu_out, dbg_rf_data, dbg_dm_data;
  logic        unused_dbg_bits;

  pipeline_cpu u_cpu (
    .clk        (clk),
    .rst        (rstn),
    .ce         (ce_q),
    .pc_out     (pc_out),
    .instr_out  (instr_out),
    .alu_out    (alu_out),
    .dbg_rf_addr(dbg_idx_q),
    .dbg_rf_data(dbg_rf_data),
    .dbg_dm_addr({1'b0, dbg_idx_q}),
    .dbg_dm_data(dbg_dm_data)
  );

  assign unused_dbg_bits = ^{dbg_rf_data[31:24], dbg_dm_data[31:24]};

  // Mask compare on the live divider, so a mode switch takes effect on the very next window.
  assign div_mask  = sw_i[15] ? SLOW_MASK : FAST_MASK;
  assign ce_d      = ((clkdiv_q & div_mask) == div_mask) & ~sw_i[1];
  assign slow_tick = (clkdiv_q & SLOW_MASK) == SLOW_MASK;
  assign scan_idx  = clkdiv_q[SCAN_L+2 -: 3];
  assign nibble    = disp_data_q[{scan_idx, 2'b00} +: 4];

  always_comb begin
    if (sw_i[14])      disp_data_d = instr_out;
    else if (sw_i[13]) disp_data_d = {3'b0, dbg_idx_q, dbg_rf_data[23:0]};
    else if (sw_i[12]) disp_data_d = alu_out;
    else if (sw_i[11]) disp_data_d = {3'b0, dbg_idx_q, dbg_dm_data[23:0]};
    else               disp_data_d = pc_out;
  end

  assign led_d = sw_i[0] ? disp_data_q[15:0] : sw_i;
  assign an_d  = ~(8'b1 << scan_idx);

  always_comb begin
    seg_d = 8'hFF;
    case (nibble)
      4'h0: seg_d = 8'hC0;
      4'h1: seg_d = 8'hF9;
      4'h2: seg_d = 8'hA4;
      4'h3: seg_d = 8'hB0;
      4'h4: seg_d = 8'h99;
      4'h5: seg_d = 8'h92;
      4'h6: seg_d = 8'h82;
      4'h7: seg_d = 8'hF8;
      4'h8: seg_d = 8'h80;
      4'h9: seg_d = 8'h90;
      4'hA: seg_d = 8'h88;
      4'hB: seg_d = 8'h83;
      4'hC: seg_d = 8'hC6;
      4'hD: seg_d = 8'hA1;
      4'hE: seg_d = 8'h86;
      4'hF: seg_d = 8'h8E;
      default: seg_d = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      clkdiv_q    <= '0;
      ce_q        <= 1'b0;
      dbg_idx_q   <= '0;
      disp_data_q <= '0;
      led_q       <= '0;
      seg_q       <= 8'hFF;
      an_q        <= 8'hFF;
    end else begin
      clkdiv_q    <= clkdiv_q + 32'd1;
      ce_q        <= ce_d;
      if (slow_tick) dbg_idx_q <= dbg_idx_q + 5'd1;
      disp_data_q <= disp_data_d;
      led_q       <= led_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign led_o      = led_q;
  assign disp_seg_o = seg_q;
  assign disp_an_o  = an_q;
endmodule

// File: tb/tb_riscv_board_top.sv
// Scoreboard bench for riscv_board_top: stimulus queues expected LED/anode/segment values per cycle,
// a negedge monitor pops and compares them. Slow and scan dividers are set to 2^4.
module tb_riscv_board_top;
  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [15:0] sw_i = 16'h0001;
  logic [15:0] led_o;
  logic [7:0]  disp_seg_o, disp_an_o;

  typedef struct {
    int          cyc;
    logic [15:0] led;
    logic [7:0]  an;
    logic [7:0]  seg;
    bit          chk_disp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  riscv_board_top #(.FAST_DIV_LOG2(1), .SLOW_DIV_LOG2(4), .SCAN_DIV_LOG2(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sw_i      (sw_i),
    .led_o     (led_o),
    .disp_seg_o(disp_seg_o),
    .disp_an_o (disp_an_o)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges since reset release
  always @(posedge clk) if (!rstn) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      n_tests++;
      if (mon_e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s missed: due cyc %0d, now %0d", mon_e.name, mon_e.cyc, cyc);
      end else if (led_o !== mon_e.led ||
                   (mon_e.chk_disp && (disp_an_o !== mon_e.an || disp_seg_o !== mon_e.seg))) begin
        n_fail++;
        $display("FAIL %s cyc=%0d led got %h exp %h, an got %h exp %h, seg got %h exp %h",
                 mon_e.name, cyc, led_o, mon_e.led, disp_an_o, mon_e.an, disp_seg_o, mon_e.seg);
      end
    end
  end

  task automatic expect_at(input int c, input logic [15:0] led, input logic [7:0] an,
                           input logic [7:0] seg, input bit chk, input string name);
    exp_t e;
    e.cyc = c; e.led = led; e.an = an; e.seg = seg; e.chk_disp = chk; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    int guard = 0;
    while (cyc < c && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  initial begin
    expect_at(0, 16'h0000, 8'hFF, 8'hFF, 1, "reset");
    #100;
    rstn = 1'b0;

    // fast: core steps on edges 3,5,7...; LED/segments show PC from two edges earlier
    expect_at(4,  16'h0000, 8'hFE, 8'hC0, 1, "fast_pc0");
    expect_at(6,  16'h0004, 8'hFE, 8'h99, 1, "fast_pc4");
    expect_at(8,  16'h0008, 8'hFE, 8'h80, 1, "fast_pc8");
    expect_at(10, 16'h000C, 8'hFE, 8'hC6, 1, "fast_pcC");
    expect_at(12, 16'h0010, 8'hFE, 8'hC0, 1, "fast_pc10_digit0");
    expect_at(14, 16'h0014, 8'hFE, 8'h99, 1, "fast_pc14");
    expect_at(16, 16'h0018, 8'hFE, 8'h80, 1, "fast_pc18");
    expect_at(17, 16'h001C, 8'hFD, 8'hF9, 1, "scan_digit1");

    wait_cyc(20);
    sw_i = 16'h0003;
    expect_at(23, 16'h0028, 8'hFD, 8'hA4, 1, "pause_last_step");
    expect_at(25, 16'h0028, 8'hFD, 8'hA4, 1, "pause_hold_a");
    expect_at(30, 16'h0028, 8'hFD, 8'hA4, 1, "pause_hold_b");
    expect_at(40, 16'h0028, 8'hFB, 8'hC0, 1, "pause_hold_c");

    wait_cyc(40);
    sw_i = 16'h0001;
    expect_at(44, 16'h0028, 8'hFB, 8'hC0, 1, "resume_wait");
    expect_at(45, 16'h002C, 8'hFB, 8'hC0, 1, "resume_first");
    expect_at(49, 16'h0034, 8'hF7, 8'hC0, 1, "resume_run");

    wait_cyc(50);
    sw_i = 16'h8001;
    expect_at(66, 16'h003C, 8'hEF, 8'hC0, 1, "slow_hold");
    expect_at(67, 16'h0040, 8'hEF, 8'hC0, 1, "slow_step1");
    expect_at(82, 16'h0040, 8'hDF, 8'hC0, 1, "slow_gap");
    expect_at(83, 16'h0044, 8'hDF, 8'hC0, 1, "slow_step2");
    expect_at(99, 16'h0048, 8'hBF, 8'hC0, 1, "slow_step3");

    wait_cyc(100);
    sw_i = 16'hC001;
    expect_at(101, 16'h0048, 8'hBF, 8'hC0, 1, "instr_lat1");
    expect_at(102, 16'h0293, 8'hBF, 8'hA4, 1, "instr_lat2");
    expect_at(104, 16'h0293, 8'hBF, 8'hA4, 1, "instr_hold");

    wait_cyc(104);
    sw_i = 16'h9001;
    expect_at(106, 16'h0123, 8'hBF, 8'hC0, 1, "alu_sel");

    wait_cyc(106);
    sw_i = 16'hA001;
    expect_at(490, 16'h0000, 8'hBF, 8'h86, 1, "rf_idx30");
    expect_at(500, 16'h0000, 8'h7F, 8'hF9, 1, "rf_idx31");
    expect_at(532, 16'h0001, 8'hFD, 8'hC0, 1, "rf_wrap_x1");
    expect_at(564, 16'h0003, 8'hF7, 8'hC0, 1, "rf_x3");
    expect_at(580, 16'h0003, 8'hEF, 8'hC0, 1, "rf_x4_load");
    expect_at(596, 16'h0123, 8'hDF, 8'hC0, 1, "rf_x5");
    expect_at(610, 16'h0000, 8'hBF, 8'h82, 1, "rf_idx6");
    expect_at(626, 16'h0000, 8'h7F, 8'hC0, 1, "rf_idx7_hi");

    wait_cyc(640);
    sw_i = 16'h8801;
    expect_at(1020, 16'h0000, 8'h7F, 8'hF9, 1, "dm_idx31");
    expect_at(1030, 16'h0003, 8'hFE, 8'hB0, 1, "dm_idx0");

    wait_cyc(1040);
    sw_i = 16'h8000;
    expect_at(1042, 16'h8000, 8'h00, 8'h00, 0, "led_raw_sw");

    begin
      int guard = 0;
      while (sb_q.size() > 0 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
    end
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: due cyc %0d, now %0d", mon_e.name, mon_e.cyc, cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
